// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer write-port controller.
package fb_pkg;

  localparam int FB_ADDR_W       = 19;
  localparam int FB_DATA_W       = 12;
  localparam int FB_FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CLEAR   = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Linear 0..FRAME_PIXELS-1 address counter; cur/last describe the address used this cycle.
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cur,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] count;

  // A clear in the same cycle as an increment makes this cycle's address 0, so the next is 1.
  assign cur  = clr ? '0 : count;
  assign last = (cur == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : cur + 1'b1;
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer port-A sequencer: camera capture, overlay arbitration, optional full-frame
// clear when FB_CLEAR_EN is defined.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              ovl_req,
  input  logic [ADDR_W-1:0] ovl_addr,
  input  logic [DATA_W-1:0] ovl_data,
  output logic              ovl_gnt,
  output logic              ovl_err,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done
);

  localparam logic [ADDR_W:0] FRAME_END = (ADDR_W + 1)'(FRAME_PIXELS);

  fb_state_t         state;
  logic              vsync_q;
  logic              vsync_rise;
  logic              cam_wr;
  logic              cam_clr;
  logic              cam_last;
  logic [ADDR_W-1:0] cam_cur;
  logic              in_clear;
  logic              ovl_take;
  logic              ovl_ok;

  assign vsync_rise = cam_vsync & ~vsync_q;
  assign cam_wr     = (state == ST_CAPTURE) & cam_valid;
  assign cam_clr    = vsync_rise & (state != ST_CLEAR);
  assign ovl_ok     = ({1'b0, ovl_addr} < FRAME_END);
  // The overlay only gets slots nobody else wants, and never twice back to back.
  assign ovl_take   = ~in_clear & ~cam_wr & ovl_req & ~ovl_gnt;
  assign busy       = (state != ST_IDLE);

  fb_addr_counter #(
    .ADDR_W      (ADDR_W),
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_cam_addr (
    .clk (clk),
    .rst (rst),
    .clr (cam_clr),
    .inc (cam_wr),
    .cur (cam_cur),
    .last(cam_last)
  );

`ifdef FB_CLEAR_EN
  logic              clr_go;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_cur;
  logic [DATA_W-1:0] clear_q;

  assign in_clear = (state == ST_CLEAR);
  assign clr_go   = (state == ST_IDLE) & clear_start & ~vsync_rise;

  fb_addr_counter #(
    .ADDR_W      (ADDR_W),
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_clear_addr (
    .clk (clk),
    .rst (rst),
    .clr (clr_go),
    .inc (in_clear),
    .cur (clr_cur),
    .last(clr_last)
  );
`else
  logic unused_clear;

  assign in_clear     = 1'b0;
  assign clear_done   = 1'b0;
  assign unused_clear = ^{clear_start, clear_color};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vsync_q    <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      ovl_gnt    <= 1'b0;
      ovl_err    <= 1'b0;
      frame_done <= 1'b0;
`ifdef FB_CLEAR_EN
      clear_done <= 1'b0;
      clear_q    <= '0;
`endif
    end else begin
      vsync_q    <= cam_vsync;
      wea        <= 1'b0;
      ovl_gnt    <= 1'b0;
      ovl_err    <= 1'b0;
      frame_done <= 1'b0;
`ifdef FB_CLEAR_EN
      clear_done <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          if (vsync_rise) begin
            state <= ST_CAPTURE;
`ifdef FB_CLEAR_EN
          end else if (clear_start) begin
            state   <= ST_CLEAR;
            clear_q <= clear_color;
`endif
          end
        end
        ST_CAPTURE: begin
          if (cam_wr && cam_last) begin
            state <= ST_IDLE;
          end
        end
`ifdef FB_CLEAR_EN
        ST_CLEAR: begin
          if (clr_last) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // Fixed priority: clear, then camera, then overlay.
`ifdef FB_CLEAR_EN
      if (in_clear) begin
        wea        <= 1'b1;
        addra      <= clr_cur;
        dina       <= clear_q;
        clear_done <= clr_last;
      end else
`endif
      if (cam_wr) begin
        wea        <= 1'b1;
        addra      <= cam_cur;
        dina       <= cam_data;
        frame_done <= cam_last;
      end else if (ovl_take) begin
        ovl_gnt <= 1'b1;
        ovl_err <= ~ovl_ok;
        wea     <= ovl_ok;
        if (ovl_ok) begin
          addra <= ovl_addr;
          dina  <= ovl_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl with a 16-pixel frame; clear checks follow FB_CLEAR_EN.
module tb_fb_write_ctrl;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int FP     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cam_vsync;
  logic              cam_valid;
  logic [DATA_W-1:0] cam_data;
  logic              ovl_req;
  logic [ADDR_W-1:0] ovl_addr;
  logic [DATA_W-1:0] ovl_data;
  logic              ovl_gnt;
  logic              ovl_err;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              busy;
  logic              frame_done;
  logic              clear_done;

  int compared   = 0;
  int mismatched = 0;

  fb_write_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .ovl_req    (ovl_req),
    .ovl_addr   (ovl_addr),
    .ovl_data   (ovl_data),
    .ovl_gnt    (ovl_gnt),
    .ovl_err    (ovl_err),
    .clear_start(clear_start),
    .clear_color(clear_color),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .busy       (busy),
    .frame_done (frame_done),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vs, input logic cv, input logic [DATA_W-1:0] cd,
                               input logic rq, input logic [ADDR_W-1:0] ra,
                               input logic [DATA_W-1:0] rd);
    cam_vsync = vs;
    cam_valid = cv;
    cam_data  = cd;
    ovl_req   = rq;
    ovl_addr  = ra;
    ovl_data  = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port check: address and data only matter when a write is expected.
  task automatic checkWrite(input string tag, input logic ew, input logic [ADDR_W-1:0] ea,
                            input logic [DATA_W-1:0] ed);
    checkOutput({tag, "_wea"}, 32'(wea), 32'(ew));
    if (ew) begin
      checkOutput({tag, "_addra"}, 32'(addra), 32'(ea));
      checkOutput({tag, "_dina"}, 32'(dina), 32'(ed));
    end
  endtask

  initial begin
    rst         = 1'b1;
    clear_start = 1'b0;
    clear_color = '0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("rst_wea", 32'(wea), 32'd0);
    checkOutput("rst_addra", 32'(addra), 32'd0);
    checkOutput("rst_dina", 32'(dina), 32'd0);
    checkOutput("rst_gnt", 32'(ovl_gnt), 32'd0);
    checkOutput("rst_err", 32'(ovl_err), 32'd0);
    checkOutput("rst_fdone", 32'(frame_done), 32'd0);
    checkOutput("rst_cdone", 32'(clear_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Full frame.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("vs1_busy", 32'(busy), 32'd1);
    checkOutput("vs1_wea", 32'(wea), 32'd0);
    for (int i = 0; i < FP; i++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(12'h100 + i), 1'b0, '0, '0);
      tick();
      checkWrite("frame", 1'b1, ADDR_W'(i), DATA_W'(12'h100 + i));
      checkOutput("frame_fdone", 32'(frame_done), (i == FP - 1) ? 32'd1 : 32'd0);
    end
    checkOutput("frame_end_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 12'h1FF, 1'b0, '0, '0);
    tick();
    checkOutput("pix17_wea", 32'(wea), 32'd0);
    checkOutput("pix17_fdone", 32'(frame_done), 32'd0);

    // Mid-frame restart.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(12'h200 + i), 1'b0, '0, '0);
      tick();
      checkWrite("pre", 1'b1, ADDR_W'(i), DATA_W'(12'h200 + i));
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("restart_wea", 32'(wea), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(12'h210 + i), 1'b0, '0, '0);
      tick();
      checkWrite("post", 1'b1, ADDR_W'(i), DATA_W'(12'h210 + i));
      checkOutput("post_fdone", 32'(frame_done), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 12'h2AA, 1'b0, '0, '0);
    tick();
    checkWrite("same_cyc0", 1'b1, 19'd0, 12'h2AA);
    applyStimulus(1'b0, 1'b1, 12'h2AB, 1'b0, '0, '0);
    tick();
    checkWrite("same_cyc1", 1'b1, 19'd1, 12'h2AB);

    // Overlay held across camera traffic.
    applyStimulus(1'b0, 1'b1, 12'h2AC, 1'b1, 19'd7, 12'hABC);
    tick();
    checkWrite("ovl_a", 1'b1, 19'd2, 12'h2AC);
    checkOutput("ovl_a_gnt", 32'(ovl_gnt), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 19'd7, 12'hABC);
    tick();
    checkWrite("ovl_b", 1'b1, 19'd7, 12'hABC);
    checkOutput("ovl_b_gnt", 32'(ovl_gnt), 32'd1);
    checkOutput("ovl_b_err", 32'(ovl_err), 32'd0);
    tick();
    checkOutput("ovl_c_wea", 32'(wea), 32'd0);
    checkOutput("ovl_c_gnt", 32'(ovl_gnt), 32'd0);
    applyStimulus(1'b0, 1'b1, 12'h2AD, 1'b0, '0, '0);
    tick();
    checkWrite("ovl_d", 1'b1, 19'd3, 12'h2AD);
    checkOutput("ovl_d_gnt", 32'(ovl_gnt), 32'd0);

    // Overlay out of range.
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 19'd20, 12'h555);
    tick();
    checkOutput("oor_gnt", 32'(ovl_gnt), 32'd1);
    checkOutput("oor_err", 32'(ovl_err), 32'd1);
    checkOutput("oor_wea", 32'(wea), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("oor_gnt_off", 32'(ovl_gnt), 32'd0);
    checkOutput("oor_err_off", 32'(ovl_err), 32'd0);

    // Asynchronous reset at address 9.
    for (int i = 4; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(12'h300 + i), 1'b0, '0, '0);
      tick();
      checkWrite("to9", 1'b1, ADDR_W'(i), DATA_W'(12'h300 + i));
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_wea", 32'(wea), 32'd0);
    checkOutput("arst_addra", 32'(addra), 32'd0);
    checkOutput("arst_dina", 32'(dina), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("rearm_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 12'h3C3, 1'b0, '0, '0);
    tick();
    checkWrite("rearm", 1'b1, 19'd0, 12'h3C3);

    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Frame clear; colour changes after the start pulse to prove it was sampled.
    clear_start = 1'b1;
    clear_color = 12'hF00;
    tick();
    clear_start = 1'b0;
    clear_color = 12'h0F0;
`ifdef FB_CLEAR_EN
    checkOutput("clr_start_wea", 32'(wea), 32'd0);
    checkOutput("clr_start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < FP; i++) begin
      cam_vsync = (i == 3);
      tick();
      checkWrite("clr", 1'b1, ADDR_W'(i), 12'hF00);
      checkOutput("clr_cdone", 32'(clear_done), (i == FP - 1) ? 32'd1 : 32'd0);
      if (i < FP - 1) checkOutput("clr_busy", 32'(busy), 32'd1);
    end
    cam_vsync = 1'b0;
    tick();
    checkOutput("clr_after_wea", 32'(wea), 32'd0);
    checkOutput("clr_after_busy", 32'(busy), 32'd0);
`else
    checkOutput("noclr_start_wea", 32'(wea), 32'd0);
    for (int i = 0; i < FP; i++) begin
      cam_vsync = (i == 3);
      tick();
      checkOutput("noclr_wea", 32'(wea), 32'd0);
      checkOutput("noclr_cdone", 32'(clear_done), 32'd0);
    end
    cam_vsync = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
